uart_rx_deframer: RTL
=====================

# uart_rx_deframer

Serial-to-parallel UART receive stage that sits directly upstream of the CPU core's input port. It synchronises the `uart_rx` pin, detects and validates start bits, and samples 8N1 frames at mid-bit. It checks the stop bit and buffers completed bytes in a small FIFO. The CPU side drains the FIFO through a valid/ready handshake; framing and overrun events are flagged as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; even, ≥ 4.
- `FIFO_DEPTH`, 4: received-byte buffer entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (`rst`=0 resets).
- `uart_rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid`&`rx_ready`.
- `rx_busy`  out  1  FSM not in IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped, FIFO full.

## Operation
- Synchroniser: 2 flops on `uart_rx`, both reset to 1; the FSM uses only the synchronised value `rxs`.
- Bit counter `cnt`, width `$clog2(CLKS_PER_BIT)`, cleared on every state entry; bit index `idx` 0–7.
- IDLE: `rxs`=0 → START.
- START: at `cnt`=CLKS_PER_BIT/2−1, sample `rxs`. Low → DATA. High → IDLE (glitch rejected, nothing flagged).
- DATA: at `cnt`=CLKS_PER_BIT−1, shift `rxs` into `shreg` LSB-first (`shreg <= {rxs, shreg[7:1]}`), `idx++`. After `idx`=7 → STOP.
- STOP: at `cnt`=CLKS_PER_BIT−1, sample `rxs`:
  - 1 → push `shreg` → IDLE. If the FIFO is full and no pop occurs in the same cycle: drop the byte, pulse `overrun`.
  - 0 → pulse `frame_err`, no push → WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1 (break/line-low handling), then → IDLE.
- FIFO: first-word-fall-through; `rx_data` = head entry, `rx_valid` = !empty.
  - Pop on `rx_valid`&`rx_ready`.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty and the pushed byte is the only candidate: the pop does not occur (`rx_valid` was 0).
- Pointers wrap modulo FIFO_DEPTH. Count width is `$clog2(FIFO_DEPTH)+1`.
- `rx_ready` high with `rx_valid` low: no effect.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - `rx_data`=8'h00.
  - FIFO empty, FSM IDLE, synchroniser=1.
- Reset mid-frame aborts the frame. The partial byte is discarded and FIFO contents are lost.
- Let cycle T be the first edge at which `rxs`=0 in IDLE.
  - START is entered at T+1.
  - Start-bit sample occurs at T+CLKS_PER_BIT/2.
  - Data bit k is sampled at T+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Stop sample occurs at T+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- Push is registered at the stop-sample edge. `rx_valid` rises on the following cycle; there is no extra cycle on the output path.
- Pin-to-`rxs` latency is 2 cycles.
- `frame_err` and `overrun` are each high for exactly one cycle, coincident with the cycle after the stop sample.
- IDLE is re-entered one cycle after the stop sample, so back-to-back frames with a 1-bit stop are received without loss.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants `UART_DATA_BITS`=8 and `UART_DEFAULT_CLKS_PER_BIT`=16.
  - The package is shared with the transmitter.
- Sub-module `byte_fifo`, parameterised by WIDTH and DEPTH: FWFT with push/pop/full/empty. It is reusable for the TX path.
- Top-level file contains only the synchroniser, counters, FSM and shift register.

## Test plan
All scenarios use CLKS_PER_BIT=16, FIFO_DEPTH=4 and 16-cycle bit period stimulus.
- Send 0x3A with `rx_ready`=1 → `rx_data`=0x3A, `rx_valid` high exactly 1 cycle, rising at T+153; no flags.
- Hold `rx_ready`=0, send 0xA5 then 0x5A back-to-back → `rx_valid` stays 1. Raising `rx_ready` yields 0xA5 then 0x5A on consecutive cycles, then `rx_valid`=0.
- `rx_ready`=0, send 0x01–0x05 → `overrun` pulses once at the 5th stop sample. Draining yields 0x01–0x04 in order.
- Send 0x55 with stop bit 0, line held low 40 cycles more → `frame_err` pulses once, no push, `rx_busy`=1 until the line returns high. A following 0x3C is then received correctly.
- 4-cycle low glitch on `uart_rx` → START aborts, `rx_busy` back to 0, `rx_valid` stays 0, no flags.
- Assert `rst` during DATA of 0xFF, release, send 0x81 → all outputs at reset values during reset, FIFO empty, only 0x81 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive deframer and the transmitter.
//   rx_state_t                : receive FSM state encoding
//   UART_DATA_BITS            : payload bits per frame (8N1)
//   UART_DEFAULT_CLKS_PER_BIT : default oversampling ratio
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO, shared by the UART RX and TX paths.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push/i_data : write strobe and data; ignored when full unless a pop
//                   happens in the same cycle
//   i_pop         : read strobe; ignored when empty
//   o_data        : head entry (valid while !o_empty)
//   o_full/o_empty: occupancy flags
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_MAX);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronises uart_rx, validates the start bit,
// samples data and stop bits at mid-bit and buffers bytes in a FWFT FIFO.
//   clk, rst   : clock, asynchronous active-low reset
//   uart_rx    : serial line, idle high
//   rx_data    : head-of-FIFO byte, valid while rx_valid
//   rx_valid   : FIFO non-empty
//   rx_ready   : consumer accepts rx_data on rx_valid & rx_ready
//   rx_busy    : receiver not idle
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped (FIFO full)
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic [1:0]                r_sync;
  logic                      w_rxs;
  rx_state_t                 r_state;
  rx_state_t                 w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_shift;
  logic w_push;
  logic w_ferr;
  logic w_pop;
  logic w_fifo_full;
  logic w_fifo_empty;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[0], uart_rx};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) w_state_nxt = START;
      end
      START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (r_cnt == CNT_HALF) w_state_nxt = w_rxs ? IDLE : DATA;
      end
      DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_shift = 1'b1;
          if (r_idx == IDX_LAST) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_cnt == CNT_FULL) begin
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Each data bit restarts the counter, so CLKS_PER_BIT need not be a
      // power of two.
      if (w_state_nxt != r_state || w_shift ||
          r_state == IDLE || r_state == WAIT_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == START) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_shift) begin
        r_shreg <= {w_rxs, r_shreg[UART_DATA_BITS-1:1]};
      end
      r_frame_err <= w_ferr;
      r_overrun   <= w_push & w_fifo_full & ~w_pop;
    end
  end

  assign w_pop     = rx_valid & rx_ready;
  assign rx_valid  = ~w_fifo_empty;
  assign rx_busy   = (r_state != IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  byte_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .i_push (w_push),
    .i_data (r_shreg),
    .i_pop  (w_pop),
    .o_data (rx_data),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

endmodule
